// File: rtl/cherry_pkg.sv
// Shared definitions for the control unit and the instruction queue.
// Holds widths, the queue entry layout and the copy-count clamp.
package cherry_pkg;

    localparam int INSTR_WIDTH       = 16;
    localparam int LOG_DEPTH         = 3;
    localparam int DEPTH             = 1 << LOG_DEPTH;
    localparam int SUPERSCALAR_WIDTH = 4;
    localparam int CW                = $clog2(SUPERSCALAR_WIDTH + 1);

    localparam logic [CW-1:0] MAX_COPIES = CW'(SUPERSCALAR_WIDTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [CW-1:0]          copies;
    } queue_entry_t;

    // Oversized copy requests are limited to the issue width.
    function automatic logic [CW-1:0] clamp_copies(input logic [CW-1:0] c);
        return (c > MAX_COPIES) ? MAX_COPIES : c;
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Entry storage for the instruction queue.
// One synchronous write port, one asynchronous read port.
module queue_ram
    import cherry_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG_DEPTH-1:0] waddr,
    input  queue_entry_t         wdata,
    input  logic [LOG_DEPTH-1:0] raddr,
    output queue_entry_t         rdata
);

    queue_entry_t mem [DEPTH];

    // Write the entry at the write pointer; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// Circular queue of {instr, copies} entries that replays each entry
// once per copy, one copy per accepted output beat.
module instruction_queue
    import cherry_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [CW-1:0]          in_copies,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [CW-1:0]          out_copy_idx,
    output logic                   out_last,
    output logic [LOG_DEPTH:0]     count,
    output logic                   drained
);

    localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH+1)'(DEPTH);

    logic [LOG_DEPTH-1:0] wp;
    logic [LOG_DEPTH-1:0] rp;
    logic [CW-1:0]        copy_idx;
    queue_entry_t         wr_entry;
    queue_entry_t         head;

    logic push_fire;
    logic push_store;
    logic beat;
    logic pop_fire;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);

    assign push_fire  = in_valid && in_ready;
    // A zero-copy entry is accepted but never stored.
    assign push_store = push_fire && (in_copies != '0);

    assign wr_entry.instr  = in_instr;
    assign wr_entry.copies = clamp_copies(in_copies);

    queue_ram u_ram (
        .clk   (clk),
        .we    (push_store),
        .waddr (wp),
        .wdata (wr_entry),
        .raddr (rp),
        .rdata (head)
    );

    // Head copy presentation; out_last is masked while empty since
    // storage behind rp is stale then.
    always_comb begin
        out_instr    = head.instr;
        out_copy_idx = copy_idx;
        out_last     = out_valid && (copy_idx == head.copies - 1'b1);
    end

    assign beat     = out_valid && out_ready;
    assign pop_fire = beat && out_last;

    assign drained = (count == '0) && (copy_idx == '0);

    // Pointer, occupancy and copy-index state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            copy_idx <= '0;
        end else begin
            if (push_store) begin
                wp <= wp + 1'b1;
            end
            if (pop_fire) begin
                rp <= rp + 1'b1;
            end
            unique case ({push_store, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (beat) begin
                copy_idx <= out_last ? '0 : copy_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue.
// Hand-computed expectations for replay, full, wrap, clamp, reset.
module tb_instruction_queue;

    import cherry_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [CW-1:0]          in_copies;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [CW-1:0]          out_copy_idx;
    logic                   out_last;
    logic [LOG_DEPTH:0]     count;
    logic                   drained;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    instruction_queue dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_copies    (in_copies),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_copy_idx (out_copy_idx),
        .out_last     (out_last),
        .count        (count),
        .drained      (drained)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] ins, input logic [CW-1:0] c);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_copies = c;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_copies = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_idx", out_copy_idx, 0);
        chk("rst_count", count, 0);
        chk("rst_drained", drained, 1);

        // Single 3-copy entry, no fall-through
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'hA001;
        in_copies = 3'd3;
        #1;
        chk("t1_no_fall", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_count", count, 1);
        for (int k = 0; k < 3; k++) begin
            chk("t1_valid", out_valid, 1);
            chk("t1_instr", out_instr, 16'hA001);
            chk("t1_idx", out_copy_idx, k);
            chk("t1_last", out_last, (k == 2));
            tick();
        end
        chk("t1_end_valid", out_valid, 0);
        chk("t1_end_count", count, 0);
        chk("t1_end_drained", drained, 1);

        // Fill to full, reject 9th, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(16'hB000 + 16'(i), 3'd1);
        end
        chk("t2_full_count", count, 8);
        chk("t2_full_ready", in_ready, 0);
        push(16'hC0DE, 3'd1);
        chk("t2_9th_count", count, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_instr", out_instr, 16'hB000 + i);
            chk("t2_last", out_last, 1);
            tick();
            if (i == 0) chk("t2_ready_back", in_ready, 1);
        end
        chk("t2_empty", count, 0);

        // Move both pointers to 7 (wp=rp=1 now)
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i), 3'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t3_pre_instr", out_instr, 16'h0100 + i);
            tick();
        end
        chk("t3_pre_count", count, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'hD000 + 16'(i), 3'd1);
        chk("t3_full", count, 8);

        // Full plus final-copy pop: push must wait a cycle
        in_valid  = 1'b1;
        in_instr  = 16'hE000;
        in_copies = 3'd1;
        out_ready = 1'b1;
        chk("t3_ready_full", in_ready, 0);
        chk("t3_head", out_instr, 16'hD000);
        tick();
        chk("t3_count7", count, 7);
        chk("t3_ready_back", in_ready, 1);
        chk("t3_wrap_rp", out_instr, 16'hD001);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t3_count8", count, 8);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t3_drain", out_instr, 16'hD000 + i);
            tick();
        end
        chk("t3_wrap_wp", out_instr, 16'hE000);
        tick();
        chk("t3_empty", count, 0);

        // Zero copies ignored, 7 copies clamped to 4
        push(16'h5555, 3'd0);
        chk("t4_zero_count", count, 0);
        chk("t4_zero_valid", out_valid, 0);
        push(16'hF00F, 3'd7);
        for (int k = 0; k < 4; k++) begin
            chk("t4_instr", out_instr, 16'hF00F);
            chk("t4_idx", out_copy_idx, k);
            chk("t4_last", out_last, (k == 3));
            tick();
        end
        chk("t4_drained", drained, 1);

        // Steady stream, no bubble
        push(16'h1000, 3'd1);
        for (int i = 1; i < 6; i++) begin
            in_valid  = 1'b1;
            in_instr  = 16'h1000 + 16'(i);
            in_copies = 3'd1;
            chk("t5_valid", out_valid, 1);
            chk("t5_instr", out_instr, 16'h1000 + i - 1);
            chk("t5_count", count, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("t5_tail", out_instr, 16'h1005);
        tick();
        chk("t5_empty", count, 0);

        // Reset mid-replay
        out_ready = 1'b0;
        push(16'h2000, 3'd4);
        push(16'h2001, 3'd2);
        push(16'h2002, 3'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_idx1", out_copy_idx, 1);
        chk("t6_count3", count, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_drained", drained, 1);
        chk("t6_idx0", out_copy_idx, 0);
        push(16'h3000, 3'd2);
        chk("t6_new_instr", out_instr, 16'h3000);
        chk("t6_new_idx0", out_copy_idx, 0);
        chk("t6_new_count", count, 1);
        out_ready = 1'b1;
        tick();
        chk("t6_new_idx1", out_copy_idx, 1);
        chk("t6_new_last", out_last, 1);
        tick();
        chk("t6_end", drained, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
